// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   8-bit up/down counter stepped by a count prescaler, converted to BCD once
//   per display frame and time-multiplexed over a 3-digit common-segment
//   7-segment display (units -> tens -> hundreds).
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_en         count enable (prescaler holds while low)
//   i_up         1 = increment, 0 = decrement
//   i_load       synchronous load strobe, priority over the count tick
//   i_load_val   value to load (clamped to MAX_COUNT)
//   o_count      current counter value
//   o_seg        segments a..g on bits 6..0, active-high
//   o_digit_sel  one-hot digit enable: [0]=units [1]=tens [2]=hundreds
//   o_wrap       1-cycle pulse when the counter wraps
//
// Build option
//   LEADING_ZERO_BLANK_EN : blank leading-zero hundreds/tens digits.
module bcd_display_scanner #(
  parameter int unsigned COUNT_DIV = 1_000_000,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_count,
  output logic [6:0] o_seg,
  output logic [2:0] o_digit_sel,
  output logic       o_wrap
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int unsigned SW = $clog2(SCAN_DIV);

  localparam logic [7:0]    MAX_V      = 8'(MAX_COUNT);
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_UNITS    = 2'd0,
    S_TENS     = 2'd1,
    S_HUNDREDS = 2'd2
  } state_t;

  // Binary to packed BCD {hundreds, tens, units} by shift-and-add-3.
  function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
    logic [19:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = {sh[18:0], 1'b0};
    end
    return sh[19:8];
  endfunction

  // Active-high 7-segment encoding, non-decimal nibbles dark.
  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [PW-1:0] r_presc;
  logic [7:0]    r_count;
  logic          r_wrap;
  logic [SW-1:0] r_scan_cnt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_snapshot;
  logic [6:0]    r_seg;
  logic [2:0]    r_digit_sel;
  logic          w_tick;
  logic          w_scan_last;
  logic [11:0]   w_bcd;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    w_seg_nxt;
  logic [2:0]    w_sel_nxt;

  assign w_tick      = i_en && (r_presc == PRESC_LAST);
  assign w_scan_last = (r_scan_cnt == SCAN_LAST);

  // Prescaler and counter; load overrides the tick and suppresses wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_load) begin
      r_presc <= '0;
      r_count <= (i_load_val > MAX_V) ? MAX_V : i_load_val;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_en) begin
        if (w_tick) begin
          r_presc <= '0;
          if (i_up) begin
            if (r_count == MAX_V) begin
              r_count <= '0;
              r_wrap  <= 1'b1;
            end else begin
              r_count <= r_count + 8'd1;
            end
          end else begin
            if (r_count == 8'd0) begin
              r_count <= MAX_V;
              r_wrap  <= 1'b1;
            end else begin
              r_count <= r_count - 8'd1;
            end
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  // Dwell counter for the current digit slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
    end else if (w_scan_last) begin
      r_scan_cnt <= '0;
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_UNITS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scan FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_scan_last) begin
      case (r_state)
        S_UNITS:    w_state_nxt = S_TENS;
        S_TENS:     w_state_nxt = S_HUNDREDS;
        default:    w_state_nxt = S_UNITS;
      endcase
    end
  end

  // Latch the count on frame start so a frame always shows one coherent value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_snapshot <= '0;
    end else if (w_scan_last && (r_state == S_HUNDREDS)) begin
      r_snapshot <= r_count;
    end
  end

  always_comb begin
    w_bcd = bin2bcd(r_snapshot);
  end

  // Scan FSM outputs: digit select and segment pattern for the current slot.
  always_comb begin
    w_sel_nxt = 3'b000;
    w_nib     = 4'd0;
    w_blank   = 1'b0;
    case (r_state)
      S_UNITS: begin
        w_sel_nxt = 3'b001;
        w_nib     = w_bcd[3:0];
      end
      S_TENS: begin
        w_sel_nxt = 3'b010;
        w_nib     = w_bcd[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank   = (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);
`endif
      end
      S_HUNDREDS: begin
        w_sel_nxt = 3'b100;
        w_nib     = w_bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank   = (w_bcd[11:8] == 4'd0);
`endif
      end
      default: begin
        w_sel_nxt = 3'b000;
      end
    endcase
    w_seg_nxt = w_blank ? 7'b0000000 : seg_enc(w_nib);
  end

  // Registered display drive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg       <= '0;
      r_digit_sel <= '0;
    end else begin
      r_seg       <= w_seg_nxt;
      r_digit_sel <= w_sel_nxt;
    end
  end

  assign o_count     = r_count;
  assign o_wrap      = r_wrap;
  assign o_seg       = r_seg;
  assign o_digit_sel = r_digit_sel;

endmodule
